// File: rtl/srt_div_sched_pkg.sv
// Shared types for the SRT divider scheduler.
// Optional feature macro: SRT_SCHED_DBZ_EN (divide-by-zero tagging).
package srt_div_pkg;
  localparam int DATA_W  = 8;
  localparam int DIV_LAT = 9;
  localparam logic [DATA_W-1:0] DBZ_QUO = 8'hFF;
  // Widest requester ID (NREQ <= 8); narrower configurations use the low bits.
  localparam int ID_W = 3;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
`ifdef SRT_SCHED_DBZ_EN
    logic              dbz;
    logic [DATA_W-1:0] op1;
`endif
  } tag_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              dbz;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
  } rsp_ent_t;
endpackage

// File: rtl/srt_div_sched_if.sv
// Request, core and response signals of the divider scheduler.
interface srt_div_sched_if #(parameter int NREQ = 4);
  import srt_div_pkg::*;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]             req_vld;
  logic [NREQ-1:0]             req_rdy;
  logic [NREQ-1:0][DATA_W-1:0] req_op1;
  logic [NREQ-1:0][DATA_W-1:0] req_op2;
  logic                        div_vld_o;
  logic [DATA_W-1:0]           div_op1_o;
  logic [DATA_W-1:0]           div_op2_o;
  logic [DATA_W-1:0]           div_quo_i;
  logic [DATA_W-1:0]           div_rem_i;
  logic                        rsp_vld;
  logic                        rsp_rdy;
  logic [IDW-1:0]              rsp_id;
  logic [DATA_W-1:0]           rsp_quo;
  logic [DATA_W-1:0]           rsp_rem;
  logic                        rsp_dbz;

  modport slave (
    input  req_vld, req_op1, req_op2, div_quo_i, div_rem_i, rsp_rdy,
    output req_rdy, div_vld_o, div_op1_o, div_op2_o,
           rsp_vld, rsp_id, rsp_quo, rsp_rem, rsp_dbz
  );

  modport master (
    output req_vld, req_op1, req_op2, div_quo_i, div_rem_i, rsp_rdy,
    input  req_rdy, div_vld_o, div_op1_o, div_op2_o,
           rsp_vld, rsp_id, rsp_quo, rsp_rem, rsp_dbz
  );
endinterface

// File: rtl/srt_div_sched_rr_arb.sv
// N-wide round-robin arbiter; pointer moves past the winner on advance.
module rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic                 adv,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (en && found) gnt[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    ptr <= '0;
    else if (adv) ptr <= (idx == IW'(N-1)) ? '0 : idx + IW'(1);
  end
endmodule

// File: rtl/srt_div_sched.sv
// Shares one fixed-latency SRT divider among NREQ requesters with credit-managed
// response buffering. Optional feature macro: SRT_SCHED_DBZ_EN.
module srt_div_sched
  import srt_div_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LAT        = DIV_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  srt_div_sched_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gidx;
  logic              issue_ok, hs;
  logic [DATA_W-1:0] op1_sel, op2_sel;
  logic [CW-1:0]     inflight, fifo_cnt, cnt_sum;

  tag_t              tag_in;
  tag_t              pipe [LAT];
  logic              retire;
  rsp_ent_t          ent;

  rsp_ent_t          mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop;
  rsp_ent_t          rsp_out;

  // Credits count everything issued but not yet popped, from registered state only.
  assign cnt_sum  = inflight + fifo_cnt;
  assign issue_ok = rstn && !flush && (cnt_sum < CW'(FIFO_DEPTH));

  rr_arb #(.N(NREQ)) u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  (bus.req_vld),
    .en   (issue_ok),
    .adv  (hs),
    .gnt  (gnt),
    .idx  (gidx)
  );

  assign hs          = |gnt;
  assign bus.req_rdy = gnt;
  assign op1_sel     = bus.req_op1[gidx];
  assign op2_sel     = bus.req_op2[gidx];
  assign bus.div_vld_o = hs;
  assign bus.div_op1_o = hs ? op1_sel : '0;
  assign bus.div_op2_o = hs ? op2_sel : '0;

  always_comb begin
    tag_in     = '0;
    tag_in.vld = hs;
    tag_in.id  = ID_W'(gidx);
`ifdef SRT_SCHED_DBZ_EN
    tag_in.dbz = hs && (op2_sel == '0);
    tag_in.op1 = op1_sel;
`endif
  end

  // Tag pipe mirrors the core pipeline, which cannot stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      if (flush) for (int k = 0; k < LAT; k++) pipe[k].vld <= 1'b0;
    end
  end

  assign retire = pipe[LAT-1].vld;

  always_comb begin
    ent     = '0;
    ent.id  = pipe[LAT-1].id;
    ent.quo = bus.div_quo_i;
    ent.rem = bus.div_rem_i;
`ifdef SRT_SCHED_DBZ_EN
    if (pipe[LAT-1].dbz) begin
      ent.dbz = 1'b1;
      ent.quo = DBZ_QUO;
      ent.rem = pipe[LAT-1].op1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                inflight <= '0;
    else if (flush)           inflight <= '0;
    else if (hs && !retire)   inflight <= inflight + CW'(1);
    else if (!hs && retire)   inflight <= inflight - CW'(1);
  end

  // Credit rule keeps the FIFO from ever being full when a retire arrives.
  assign push = retire;
  assign pop  = bus.rsp_vld && bus.rsp_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= ent;
  end

  // Payload is masked so every output reads zero while the FIFO is empty.
  assign bus.rsp_vld = (fifo_cnt != '0);
  assign rsp_out     = bus.rsp_vld ? mem[rd_ptr] : '0;
  assign bus.rsp_id  = IDW'(rsp_out.id);
  assign bus.rsp_quo = rsp_out.quo;
  assign bus.rsp_rem = rsp_out.rem;
  // Without the DBZ feature ent.dbz is constant zero, so this output is tied low.
  assign bus.rsp_dbz = rsp_out.dbz;
endmodule

// File: tb/tb_srt_div_sched.sv
// Randomized scoreboard bench for srt_div_sched with a behavioural core model.
module tb_srt_div_sched;
  import srt_div_pkg::*;

  localparam int NREQ  = 4;
  localparam int LAT   = 9;
  localparam int DEPTH = 4;
  localparam int M_NONE = 0, M_ALL = 1, M_RND = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  srt_div_sched_if #(.NREQ(NREQ)) bus();

  srt_div_sched #(.NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    int         id;
    logic [7:0] quo;
    logic [7:0] rem;
    logic       dbz;
    int         rdy_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   ptr_m = 0, outst = 0;
  int   tmo = 0;
  logic end_req = 1'b0, end_done = 1'b0;
  logic [NREQ-1:0] hs_m = '0;

  // Divider core as seen from outside: fixed latency, arbitrary result on x/0.
  function automatic logic [15:0] core_div(logic [7:0] a, logic [7:0] b);
    if (b == 8'd0) return {8'hA5, a ^ 8'h3C};
    return {a / b, a % b};
  endfunction

  function automatic exp_t ref_op(int id, logic [7:0] a, logic [7:0] b, int rdy);
    exp_t e;
    logic [15:0] r;
    r = core_div(a, b);
    e.id = id; e.quo = r[15:8]; e.rem = r[7:0]; e.dbz = 1'b0; e.rdy_cyc = rdy;
`ifdef SRT_SCHED_DBZ_EN
    if (b == 8'd0) begin e.quo = 8'hFF; e.rem = a; e.dbz = 1'b1; end
`endif
    return e;
  endfunction

  // Core model
  logic       st_v = 1'b0;
  logic [7:0] st_a = '0, st_b = '0;
  logic [7:0] cq [LAT];
  logic [7:0] cr [LAT];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = LAT-1; k > 0; k--) begin
      cq[k] <= cq[k-1];
      cr[k] <= cr[k-1];
    end
    if (st_v) {cq[0], cr[0]} <= core_div(st_a, st_b);
    else      {cq[0], cr[0]} <= 16'($urandom);
  end
  assign bus.div_quo_i = cq[LAT-1];
  assign bus.div_rem_i = cr[LAT-1];

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int g, c, popped;
    logic [NREQ-1:0] exp_rdy;
    logic exp_rv;
    st_v = bus.div_vld_o; st_a = bus.div_op1_o; st_b = bus.div_op2_o;
    if (!rstn) begin
      chk("rst_req_rdy", int'(bus.req_rdy), 0);
      chk("rst_div_vld", int'(bus.div_vld_o), 0);
      chk("rst_div_op",  int'({bus.div_op1_o, bus.div_op2_o}), 0);
      chk("rst_rsp_vld", int'(bus.rsp_vld), 0);
      chk("rst_rsp_dat", int'({bus.rsp_id, bus.rsp_quo, bus.rsp_rem, bus.rsp_dbz}), 0);
      q.delete(); outst = 0; ptr_m = 0; hs_m = '0;
    end else begin
      g = -1;
      if (!flush && outst < DEPTH)
        for (int k = 0; k < NREQ; k++) begin
          c = (ptr_m + k) % NREQ;
          if (g < 0 && bus.req_vld[c]) g = c;
        end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_rdy", int'(bus.req_rdy), int'(exp_rdy));
      chk("div_vld", int'(bus.div_vld_o), int'(g >= 0));
      chk("div_op1", int'(bus.div_op1_o), g >= 0 ? int'(bus.req_op1[g]) : 0);
      chk("div_op2", int'(bus.div_op2_o), g >= 0 ? int'(bus.req_op2[g]) : 0);
      exp_rv = (q.size() > 0) && (cyc >= q[0].rdy_cyc);
      chk("rsp_vld", int'(bus.rsp_vld), int'(exp_rv));
      popped = 0;
      if (!flush && bus.rsp_vld && bus.rsp_rdy && q.size() > 0) begin
        chk("rsp_id",  int'(bus.rsp_id),  q[0].id);
        chk("rsp_quo", int'(bus.rsp_quo), int'(q[0].quo));
        chk("rsp_rem", int'(bus.rsp_rem), int'(q[0].rem));
        chk("rsp_dbz", int'(bus.rsp_dbz), int'(q[0].dbz));
        void'(q.pop_front());
        popped = 1;
      end
      hs_m = bus.req_vld & bus.req_rdy;
      if (flush) begin
        q.delete();
        outst = 0;
      end else begin
        if (g >= 0) begin
          q.push_back(ref_op(g, bus.req_op1[g], bus.req_op2[g], cyc + LAT + 1));
          ptr_m = (g + 1) % NREQ;
          outst++;
        end
        outst -= popped;
      end
      if (end_req && !end_done) begin
        chk("drain_empty", q.size(), 0);
        chk("timeouts", tmo, 0);
        end_done = 1'b1;
      end
    end
  end

  // Stimulus
  task automatic run(int n, int mode);
    repeat (n) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_vld[i] || hs_m[i]) begin
          bus.req_vld[i] = (mode == M_ALL) || (mode == M_RND && $urandom_range(0, 1) == 1);
          bus.req_op1[i] = 8'($urandom);
          bus.req_op2[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        end
      if (mode == M_NONE) bus.req_vld = '0;
      if (mode == M_RND) begin
        bus.rsp_rdy = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 49) == 0);
      end else flush = 1'b0;
    end
  endtask

  task automatic issue_one(int i, logic [7:0] a, logic [7:0] b);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    bus.req_vld = '0;
    bus.req_vld[i] = 1'b1;
    bus.req_op1[i] = a;
    bus.req_op2[i] = b;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      done = hs_m[i];
    end
    if (!done) tmo++;
    bus.req_vld = '0;
  endtask

  initial begin
    bus.req_vld = '0; bus.req_op1 = '0; bus.req_op2 = '0; bus.rsp_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // single op: 100/7 from requester 2
    bus.rsp_rdy = 1'b1;
    issue_one(2, 8'd100, 8'd7);
    run(15, M_NONE);

    // all requesters busy, round-robin order
    run(40, M_ALL);
    // backpressure then release
    bus.rsp_rdy = 1'b0;
    run(20, M_ALL);
    bus.rsp_rdy = 1'b1;
    run(20, M_ALL);
    run(20, M_NONE);

    // random traffic with random backpressure and flushes
    run(400, M_RND);
    flush = 1'b0; bus.rsp_rdy = 1'b1;
    run(20, M_NONE);

    // divide by zero followed by 9/3
    issue_one(1, 8'h5A, 8'h00);
    issue_one(3, 8'd9, 8'd3);
    run(20, M_NONE);

    // flush with work in flight and buffered
    bus.rsp_rdy = 1'b0;
    run(8, M_ALL);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; bus.req_vld = '0;
    run(20, M_NONE);
    bus.rsp_rdy = 1'b1;
    issue_one(0, 8'd200, 8'd13);
    run(15, M_NONE);

    // asynchronous reset mid-stream
    run(12, M_ALL);
    @(posedge clk); #3 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    run(20, M_ALL);
    run(5, M_NONE);

    for (int k = 0; k < 100 && q.size() > 0; k++) @(posedge clk);
    end_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
